// File: rtl/fsk_demod.sv
// rtl/fsk_demod.sv - zero-crossing FSK demodulator with SEARCH/TRACK lock; FSK_DEMOD_HYST_EN selects the hysteresis detector
module fsk_demod #(
    parameter int SYM_LEN = 1024,
    parameter int THRESH  = 12,
    parameter int MIN_ACT = 2,
    parameter int HYST    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       sym_sync,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       locked,
    output logic [7:0] count_out
);

    localparam int               WCW     = $clog2(SYM_LEN);
    localparam logic [WCW-1:0]   WC_LAST = WCW'(SYM_LEN - 1);
    localparam logic [31:0]      THR     = 32'(THRESH);
    localparam logic [31:0]      ACT_MIN = 32'(MIN_ACT);

`ifdef FSK_DEMOD_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // A zero-width band makes both thresholds 128, i.e. a plain MSB crossing.
    localparam int         BAND  = HYST_ON ? HYST : 0;
    localparam logic [7:0] LO_TH = 8'(128 - BAND);
    localparam logic [7:0] HI_TH = 8'(128 + BAND);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SEARCH1,
        ST_TRACK
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [7:0]     din_q;
    logic           armed;
    logic [WCW-1:0] wc;
    logic [7:0]     cnt;
    logic [7:0]     cnt_next;
    logic           arm_cond;
    logic           fire_cond;
    logic           xe;
    logic           eow;
    logic           act;
    logic           bit_d;

    assign arm_cond  = din_q <  LO_TH;
    assign fire_cond = din_q >= HI_TH;
    assign xe        = armed && fire_cond;

    assign cnt_next  = (cnt == 8'd255) ? 8'd255 : cnt + 8'(xe);
    assign eow       = (wc == WC_LAST);
    assign act       = 32'(cnt_next) >= ACT_MIN;
    assign bit_d     = 32'(cnt_next) >  THR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 8'd128;
            armed <= 1'b0;
        end else begin
            din_q <= din;
            if (arm_cond) begin
                armed <= 1'b1;
            end else if (xe) begin
                armed <= 1'b0;
            end
        end
    end

    // A sync landing on the last window cycle is just a normal window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc        <= '0;
            cnt       <= '0;
            count_out <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (eow) begin
                wc        <= '0;
                cnt       <= '0;
                count_out <= cnt_next;
                if (state == ST_TRACK) begin
                    bit_out   <= bit_d;
                    bit_valid <= 1'b1;
                end
            end else if (sym_sync) begin
                wc  <= '0;
                cnt <= '0;
            end else begin
                wc  <= wc + WCW'(1);
                cnt <= cnt_next;
            end
        end
    end

    always_comb begin
        state_d = state;
        if (eow) begin
            case (state)
                ST_SEARCH:  if (act) state_d = ST_SEARCH1;
                ST_SEARCH1: state_d = act ? ST_TRACK : ST_SEARCH;
                ST_TRACK:   if (!act) state_d = ST_SEARCH;
                default:    state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
        end else begin
            state  <= state_d;
            locked <= (state_d == ST_TRACK);
        end
    end

endmodule

// File: tb/tb_fsk_demod.sv
// tb/tb_fsk_demod.sv - directed self-checking bench for fsk_demod
`timescale 1ns/1ps
module tb_fsk_demod;

    localparam int  SYM_LEN = 1024;
    localparam real PI      = 3.14159265358979;

`ifdef FSK_DEMOD_HYST_EN
    localparam int LOSS_CNT  = 0;
    localparam int NOISE_CNT = 0;
`else
    // The trough left armed by the last carrier window fires once on the first 128.
    localparam int LOSS_CNT  = 1;
    localparam int NOISE_CNT = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       sym_sync;
    logic       bit_out;
    logic       bit_valid;
    logic       locked;
    logic [7:0] count_out;

    fsk_demod dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sym_sync  (sym_sync),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .locked    (locked),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vq[$];
    int cq[$];
    int tq[$];
    always @(negedge clk) begin
        if (rst_n && bit_valid) begin
            vq.push_back(int'(bit_out));
            cq.push_back(int'(count_out));
            tq.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_bad = 0;
    int sync_cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int qb(input int i);
        return (i < vq.size()) ? vq[i] : -1;
    endfunction

    function automatic int qc(input int i);
        return (i < cq.size()) ? cq[i] : -1;
    endfunction

    function automatic int qt(input int i);
        return (i < tq.size()) ? tq[i] : -1;
    endfunction

    // mode 0: idle, 2: 124/132 noise, 3: 0/255 square, else -cos at mode/256 fclk
    function automatic logic [7:0] smp(input int mode, input int n);
        real ph;
        real v;
        case (mode)
            0: return 8'd128;
            2: return (n % 2 == 0) ? 8'd124 : 8'd132;
            3: return (n % 2 == 0) ? 8'd0 : 8'd255;
            default: begin
                ph = 2.0 * PI * real'(mode) * real'(n) / 256.0;
                v  = 128.0 - 100.0 * $cos(ph);
                return 8'($rtoi(v + 0.5));
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input int mode, input bit sync, input int len);
        for (int n = 0; n < len; n++) begin
            din      = smp(mode, n);
            sym_sync = sync && (n == 0);
            if (sym_sync) sync_cyc = cyc;
            step();
        end
        sym_sync = 1'b0;
    endtask

    task automatic reset_dut();
        din   = 8'd128;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        din      = 8'd128;
        sym_sync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din = 8'($urandom);
            step();
        end
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_bit_valid", int'(bit_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_count_out", int'(count_out), 0);

        rst_n = 1'b1;
        for (int j = 1; j < SYM_LEN; j++) begin
            din = smp(3, j);
            step();
        end
        check("first_win_before_end", int'(count_out), 0);
        step();
        check("first_win_end_sat", int'(count_out), 255);

        reset_dut();
        repeat (5 * SYM_LEN) step();
        check("idle_count", int'(count_out), 0);
        check("idle_locked", int'(locked), 0);
        check("idle_no_valid", vq.size(), 0);

        run_window(5, 1'b1, SYM_LEN);
        run_window(5, 1'b0, SYM_LEN);
        check("acq_not_locked", int'(locked), 0);
        run_window(1, 1'b0, SYM_LEN);
        check("acq_locked", int'(locked), 1);
        check("acq_no_valid", vq.size(), 0);
        run_window(5, 1'b0, SYM_LEN);
        run_window(1, 1'b0, SYM_LEN);
        run_window(5, 1'b0, SYM_LEN);
        run_window(5, 1'b0, 501);
        check("dec_nbits", vq.size(), 4);
        check("dec_bit0", qb(0), 0);
        check("dec_bit1", qb(1), 1);
        check("dec_bit2", qb(2), 0);
        check("dec_bit3", qb(3), 1);
        check("dec_cnt0", qc(0), 4);
        check("dec_cnt1", qc(1), 20);
        check("dec_cnt2", qc(2), 4);
        check("dec_cnt3", qc(3), 20);
        check("dec_cadence", qt(1) - qt(0), SYM_LEN);

        run_window(5, 1'b1, SYM_LEN);
        check("resync_discard", vq.size(), 4);

        run_window(0, 1'b0, SYM_LEN);
        run_window(0, 1'b0, 4);
        check("loss_nbits", vq.size(), 6);
        check("resync_bit", qb(4), 1);
        check("resync_cnt", qc(4), 20);
        check("resync_latency", qt(4) - sync_cyc, SYM_LEN + 1);
        check("loss_bit", qb(5), 0);
        check("loss_cnt", qc(5), LOSS_CNT);
        check("loss_unlocked", int'(locked), 0);

        run_window(5, 1'b1, SYM_LEN);
        run_window(5, 1'b0, SYM_LEN);
        run_window(5, 1'b0, SYM_LEN);
        run_window(5, 1'b0, 300);
        check("relock_locked", int'(locked), 1);
        check("relock_bit", int'(bit_out), 1);
        check("relock_cnt", int'(count_out), 20);
        check("relock_nbits", vq.size(), 7);

        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_bit_out", int'(bit_out), 0);
        check("async_rst_locked", int'(locked), 0);
        check("async_rst_count", int'(count_out), 0);
        check("async_rst_valid", int'(bit_valid), 0);
        step();
        rst_n = 1'b1;

        run_window(2, 1'b1, SYM_LEN);
        run_window(0, 1'b0, 2);
        check("noise_count", int'(count_out), NOISE_CNT);
        check("noise_no_valid", vq.size(), 7);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
